// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = the environment that feeds bytes and owns the memory.
interface prog_loader_if #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 32
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  mem_we;
    logic [SELEC_SIZE-1:0] mem_address;
    logic [DATA_SIZE-1:0]  mem_data;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        input  start, rx_data, rx_valid,
        output mem_we, mem_address, mem_data, cpu_hold, busy, done, error
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  mem_we, mem_address, mem_data, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a big-endian word-count header from a byte stream and writes
// the following words into instruction memory at word addresses 0..N-1, holding the CPU meanwhile.
module prog_loader #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 32,
    parameter int ADDRESSES  = 65536
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Wide enough to compare a word index against count-1 without truncating either side.
    localparam int          CMP_W       = (SELEC_SIZE > 32) ? SELEC_SIZE : 32;
    localparam logic [32:0] COUNT_LIMIT = 33'(ADDRESSES);

    state_t                state_reg,       state_next;
    logic [1:0]            byte_cnt_reg,    byte_cnt_next;
    logic [23:0]           shift_reg,       shift_next;
    logic [SELEC_SIZE-1:0] word_idx_reg,    word_idx_next;
    logic [31:0]           count_reg,       count_next;
    logic                  mem_we_reg,      mem_we_next;
    logic [SELEC_SIZE-1:0] mem_address_reg, mem_address_next;
    logic [DATA_SIZE-1:0]  mem_data_reg,    mem_data_next;
    logic                  cpu_hold_reg,    cpu_hold_next;
    logic                  busy_reg,        busy_next;
    logic                  done_reg,        done_next;
    logic                  error_reg,       error_next;

    logic        loading;
    logic        byte_fire;
    logic        word_fire;
    logic        start_fire;
    logic [31:0] assembled;
    logic        hdr_zero;
    logic        hdr_oversize;
    logic        word_last;

    // Only HDR and DATA consume bytes; the fourth byte of a group completes a 32-bit word.
    assign loading      = (state_reg == HDR) || (state_reg == DATA);
    assign byte_fire    = loading && bus.rx_valid;
    assign word_fire    = byte_fire && (byte_cnt_reg == 2'd3);
    assign start_fire   = !loading && bus.start;
    assign assembled    = {shift_reg, bus.rx_data};
    assign hdr_zero     = (assembled == 32'd0);
    assign hdr_oversize = ({1'b0, assembled} > COUNT_LIMIT);
    assign word_last    = (CMP_W'(word_idx_reg) == (CMP_W'(count_reg) - CMP_W'(1)));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (word_fire) begin
                    if (hdr_zero) begin
                        state_next = DONE;
                    end else if (hdr_oversize) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_fire && word_last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values; status flags follow the state being entered.
    always_comb begin
        byte_cnt_next    = byte_cnt_reg;
        shift_next       = shift_reg;
        word_idx_next    = word_idx_reg;
        count_next       = count_reg;
        mem_we_next      = 1'b0;
        mem_address_next = mem_address_reg;
        mem_data_next    = mem_data_reg;

        if (start_fire) begin
            byte_cnt_next = 2'd0;
            word_idx_next = '0;
        end

        if (byte_fire) begin
            shift_next    = {shift_reg[15:0], bus.rx_data};
            byte_cnt_next = byte_cnt_reg + 2'd1;
        end

        if (word_fire && (state_reg == HDR)) begin
            count_next = assembled;
        end

        if (word_fire && (state_reg == DATA)) begin
            mem_we_next      = 1'b1;
            mem_address_next = word_idx_reg;
            mem_data_next    = DATA_SIZE'(assembled);
            word_idx_next    = word_idx_reg + SELEC_SIZE'(1);
        end

        cpu_hold_next = (state_next == HDR) || (state_next == DATA) || (state_next == ERR);
        busy_next     = (state_next == HDR) || (state_next == DATA);
        done_next     = (state_next == DONE);
        error_next    = (state_next == ERR);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_reg    <= 2'd0;
            shift_reg       <= 24'd0;
            word_idx_reg    <= '0;
            count_reg       <= 32'd0;
            mem_we_reg      <= 1'b0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            cpu_hold_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            byte_cnt_reg    <= byte_cnt_next;
            shift_reg       <= shift_next;
            word_idx_reg    <= word_idx_next;
            count_reg       <= count_next;
            mem_we_reg      <= mem_we_next;
            mem_address_reg <= mem_address_next;
            mem_data_reg    <= mem_data_next;
            cpu_hold_reg    <= cpu_hold_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            error_reg       <= error_next;
        end
    end

    assign bus.mem_we      = mem_we_reg;
    assign bus.mem_address = mem_address_reg;
    assign bus.mem_data    = mem_data_reg;
    assign bus.cpu_hold    = cpu_hold_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.error       = error_reg;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected memory writes, a negedge
// monitor pops and compares each mem_we pulse; status flags are checked inline.
module tb_prog_loader;
    localparam int ADDR_N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_loader_if #(.DATA_SIZE(32), .SELEC_SIZE(32)) bus ();

    prog_loader #(
        .DATA_SIZE (32),
        .SELEC_SIZE(32),
        .ADDRESSES (ADDR_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                         bus.mem_address, bus.mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.mem_address !== mon_e.addr || bus.mem_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_address, bus.mem_data, mon_e.addr, mon_e.data);
                end else begin
                    $display("write addr=%h data=%h ok", bus.mem_address, bus.mem_data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    // Status vector order: {cpu_hold, busy, done, error}
    task automatic status(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.cpu_hold, bus.busy, bus.done, bus.error};
        chk(name, {28'd0, act}, {28'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        idle(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    task automatic drain(input string name);
        idle(3);
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        status("reset_status", 4'b0000);
        chk("reset_we",   {31'd0, bus.mem_we}, 32'd0);
        chk("reset_addr", bus.mem_address, 32'd0);
        chk("reset_data", bus.mem_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal back-to-back load of two words
        expect_write(32'd0, 32'h24080005);
        expect_write(32'd1, 32'h0000000C);
        pulse_start();
        status("t1_hdr", 4'b1100);
        send_word(32'd2, 0);
        status("t1_data", 4'b1100);
        send_word(32'h24080005, 0);
        send_word(32'h0000000C, 0);
        status("t1_done", 4'b0010);
        chk("t1_last_we", {31'd0, bus.mem_we}, 32'd1);
        drain("t1_drain");

        // Same image with bytes spaced 7 cycles apart and noise on rx_data
        expect_write(32'd0, 32'h24080005);
        expect_write(32'd1, 32'h0000000C);
        pulse_start();
        send_word(32'd2, 6);
        send_word(32'h24080005, 6);
        send_word(32'h0000000C, 6);
        status("t2_done", 4'b0010);
        drain("t2_drain");

        // Zero count completes without writes; trailing bytes ignored
        pulse_start();
        send_word(32'd0, 0);
        status("t3_done", 4'b0010);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        status("t3_still_done", 4'b0010);
        drain("t3_drain");

        // Oversize count (17 > 16) aborts; then a full-depth load of 16 words
        pulse_start();
        send_word(32'd17, 0);
        status("t4_err", 4'b1001);
        send_word(32'hAABBCCDD, 0);
        status("t4_still_err", 4'b1001);
        drain("t4_drain_err");
        pulse_start();
        status("t4_restart", 4'b1100);
        send_word(32'd16, 0);
        for (int i = 0; i < ADDR_N; i++) begin
            w = 32'h10000000 + 32'(i) * 32'h00010203;
            expect_write(32'(i), w);
            send_word(w, 0);
        end
        status("t4_full_done", 4'b0010);
        drain("t4_drain_full");

        // Reset in the middle of the second word
        expect_write(32'd0, 32'hA1B2C3D4);
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'hA1B2C3D4, 0);
        send_byte(8'hE5, 0);
        send_byte(8'hF6, 0);
        #3;
        rst = 1'b1;
        #1;
        status("t5_rst_status", 4'b0000);
        chk("t5_rst_we",   {31'd0, bus.mem_we}, 32'd0);
        chk("t5_rst_addr", bus.mem_address, 32'd0);
        chk("t5_rst_data", bus.mem_data, 32'd0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        rst = 1'b0;
        send_word(32'h01020304, 0);
        status("t5_idle", 4'b0000);
        drain("t5_drain_idle");
        expect_write(32'd0, 32'h3C011001);
        expect_write(32'd1, 32'h34210004);
        expect_write(32'd2, 32'h8C220000);
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'h3C011001, 0);
        send_word(32'h34210004, 0);
        send_word(32'h8C220000, 0);
        status("t5_done", 4'b0010);
        drain("t5_drain");

        // Byte alongside start is dropped; start during DATA is ignored
        expect_write(32'd0, 32'hDEADBEEF);
        expect_write(32'd1, 32'h01020304);
        bus.rx_data  = 8'hFF;
        bus.rx_valid = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        send_word(32'd2, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        bus.rx_data  = 8'hBE;
        bus.rx_valid = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        status("t6_busy", 4'b1100);
        send_byte(8'hEF, 0);
        pulse_start();
        send_word(32'h01020304, 0);
        status("t6_done", 4'b0010);
        send_word(32'hCAFEF00D, 0);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
